// File: rtl/mpu_row_sequencer_if.sv
// Command/result bundle between the MPU command decoder (master) and the row sequencer (slave).
// Matrices are flattened ROWSxCOLS, element (r,c) at bits [W*(COLS*r+c) +: W].
interface mpu_row_sequencer_if #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5,
  parameter int unsigned W    = 8
);
  logic                       start;
  logic [1:0]                 opcode;
  logic [ROWS*COLS*W-1:0]     matrix_a;
  logic [ROWS*COLS*W-1:0]     matrix_b;
  logic [W-1:0]               scalar;
  logic                       busy;
  logic                       done;
  logic [2:0]                 row_idx;
  logic [ROWS*COLS*W-1:0]     result;

  modport master (
    output start, opcode, matrix_a, matrix_b, scalar,
    input  busy, done, row_idx, result
  );

  modport slave (
    input  start, opcode, matrix_a, matrix_b, scalar,
    output busy, done, row_idx, result
  );
endinterface

// File: rtl/mpu_row_sequencer.sv
// Element-wise 5x5 int8 ADD/SUB/OPP/SMUL over one shared row ALU, one row per cycle.
// Optional macro MPU_SATURATE_EN: clamp each lane to the signed W-bit range instead of wrapping.
module mpu_row_sequencer #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5,
  parameter int unsigned W    = 8
) (
  input logic                clock,
  input logic                reset,
  mpu_row_sequencer_if.slave bus
);
  localparam int unsigned ROW_W = COLS * W;
  localparam int unsigned MAT_W = ROWS * ROW_W;
  localparam logic signed [2*W-1:0] SAT_MAX = (2*W)'((1 << (W-1)) - 1);
  localparam logic signed [2*W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_OPP, OP_SMUL} op_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_row;
  op_t                r_op;
  logic [MAT_W-1:0]   r_a;
  logic [MAT_W-1:0]   r_b;
  logic [W-1:0]       r_scalar;
  logic [MAT_W-1:0]   r_result;
  logic [ROW_W-1:0]   w_row_a;
  logic [ROW_W-1:0]   w_row_b;
  logic [ROW_W-1:0]   w_row_res;
  logic               w_last_row;

  // All opcodes share one 2W-bit signed path: wide enough for the 9-bit sums and the full product.
  function automatic logic [W-1:0] lane(input op_t op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] s);
    logic signed [2*W-1:0] ea;
    logic signed [2*W-1:0] eb;
    logic signed [2*W-1:0] es;
    logic signed [2*W-1:0] wide;
    ea   = {{W{a[W-1]}}, a};
    eb   = {{W{b[W-1]}}, b};
    es   = {{W{s[W-1]}}, s};
    wide = '0;
    unique case (op)
      OP_ADD:  wide = ea + eb;
      OP_SUB:  wide = ea - eb;
      OP_OPP:  wide = '0 - ea;
      OP_SMUL: wide = ea * es;
      default: wide = '0;
    endcase
`ifdef MPU_SATURATE_EN
    if (wide > SAT_MAX)
      return SAT_MAX[W-1:0];
    else if (wide < SAT_MIN)
      return SAT_MIN[W-1:0];
    else
      return wide[W-1:0];
`else
    return wide[W-1:0];
`endif
  endfunction

  assign w_last_row = (r_row == 3'(ROWS - 1));
  assign w_row_a    = r_a[32'(r_row) * ROW_W +: ROW_W];
  assign w_row_b    = r_b[32'(r_row) * ROW_W +: ROW_W];

  always_comb begin
    w_row_res = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      w_row_res[c*W +: W] = lane(r_op, w_row_a[c*W +: W], w_row_b[c*W +: W], r_scalar);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last_row) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_scalar <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= op_t'(bus.opcode);
            r_a      <= bus.matrix_a;
            r_b      <= bus.matrix_b;
            r_scalar <= bus.scalar;
            r_row    <= '0;
          end
        end
        S_EXEC: begin
          r_result[32'(r_row) * ROW_W +: ROW_W] <= w_row_res;
          r_row <= w_last_row ? '0 : r_row + 3'd1;
        end
        S_DONE:  r_row <= '0;
        default: r_row <= '0;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.row_idx = r_row;
  assign bus.result  = r_result;
endmodule
